htl_delay_checker: RTL and testbench

Measurement and verdict stage placed directly downstream of the High-to-Low path controller. It counts the clock cycles during which the controller holds `ld_reg` high (the falling-edge propagation window of the path under test), latches the count when the controller raises `fin`, and compares it against a golden delay window. It reports a Trojan verdict, or a timeout or protocol error, through a valid/ack result handshake to the readout logic.

---
 rtl/htl_delay_checker.sv | 119 +++++++++++
 tb/tb_htl_delay_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/htl_delay_checker.sv
// Delay measurement and verdict stage behind the High-to-Low path controller.
// Counts ld_reg cycles until fin, checks the count against a golden window and
// hands the verdict to readout through a valid/ack handshake.
module htl_delay_checker #(
    parameter int            CW      = 16,
    parameter logic [CW-1:0] TIMEOUT = CW'(1000)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_reg,
    input  logic          fin,
    input  logic [CW-1:0] golden_min,
    input  logic [CW-1:0] golden_max,
    input  logic          result_ack,
    output logic [CW-1:0] delay_count,
    output logic          trojan,
    output logic          timeout_err,
    output logic          proto_err,
    output logic          result_valid,
    output logic          busy,
    output logic [2:0]    dbgState
);

    // Handshake: result_valid rises on entry to HOLD and stays high with all
    // result fields frozen; the first cycle with result_valid && result_ack
    // moves to DONE and result_valid drops on the following edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MEASURE = 3'd1,
        DECIDE  = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] delayCnt;
    logic [CW-1:0] measCnt;
    logic [CW-1:0] delayNext;
    logic [CW-1:0] measNext;

    always_comb begin
        delayNext = delayCnt;
        if (ld_reg && (delayCnt != {CW{1'b1}})) begin
            delayNext = delayCnt + 1'b1;
        end
        measNext = measCnt;
        if (measCnt != {CW{1'b1}}) begin
            measNext = measCnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            delayCnt     <= '0;
            measCnt      <= '0;
            delay_count  <= '0;
            trojan       <= 1'b0;
            timeout_err  <= 1'b0;
            proto_err    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fin) begin
                        proto_err    <= 1'b1;
                        trojan       <= 1'b1;
                        delay_count  <= '0;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end else if (ld_reg) begin
                        delayCnt <= CW'(1);
                        measCnt  <= '0;
                        state    <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (fin) begin
                        delay_count <= delayCnt;
                        state       <= DECIDE;
                    end else begin
                        // The ld_reg sample on the expiring edge still counts.
                        delayCnt <= delayNext;
                        measCnt  <= measNext;
                        if (measNext >= TIMEOUT) begin
                            timeout_err  <= 1'b1;
                            trojan       <= 1'b1;
                            delay_count  <= delayNext;
                            result_valid <= 1'b1;
                            state        <= HOLD;
                        end
                    end
                end
                DECIDE: begin
                    trojan <= (golden_min > golden_max) ||
                              (delay_count < golden_min) ||
                              (delay_count > golden_max);
                    result_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // fin stays high upstream, so only reset leaves DONE.
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == MEASURE) || (state == DECIDE);
    assign dbgState = state;

endmodule

// File: tb/tb_htl_delay_checker.sv
// Randomized self-checking bench for htl_delay_checker with a sequence-level
// reference model of the measured delay, verdict and timing.
module tb_htl_delay_checker;

    localparam int CW = 16;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_reg;
    logic          fin;
    logic [CW-1:0] golden_min;
    logic [CW-1:0] golden_max;
    logic          result_ack;
    logic [CW-1:0] delay_count;
    logic          trojan;
    logic          timeout_err;
    logic          proto_err;
    logic          result_valid;
    logic          busy;
    logic [2:0]    dbgState;

    htl_delay_checker #(.CW(CW), .TIMEOUT(CW'(TO))) dut (
        .clk(clk),
        .rst(rst),
        .ld_reg(ld_reg),
        .fin(fin),
        .golden_min(golden_min),
        .golden_max(golden_max),
        .result_ack(result_ack),
        .delay_count(delay_count),
        .trojan(trojan),
        .timeout_err(timeout_err),
        .proto_err(proto_err),
        .result_valid(result_valid),
        .busy(busy),
        .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    int            nCompared = 0;
    int            nMismatch = 0;
    logic [CW-1:0] expQ[$];
    bit            stim[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, ".delay"}, delay_count, 0);
        checkEq({tag, ".trojan"}, trojan, 0);
        checkEq({tag, ".timeout"}, timeout_err, 0);
        checkEq({tag, ".proto"}, proto_err, 0);
        checkEq({tag, ".valid"}, result_valid, 0);
        checkEq({tag, ".busy"}, busy, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; ld_reg = 1'b0; fin = 1'b0; result_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("reset");
    endtask

    task automatic idleCycles();
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_reg = 1'b0; fin = 1'b0; result_ack = 1'($urandom_range(0, 1));
            checkEq("idleValid", result_valid, 0);
        end
    endtask

    // Measurement is the ld_reg samples from the IDLE exit edge onward; a
    // timeout fires once TO MEASURE cycles pass without fin.
    function automatic void refModel(input logic [CW-1:0] gmin, input logic [CW-1:0] gmax,
                                     output bit isTimeout, output int count, output bit expTrojan);
        int lastIdx;
        isTimeout = (stim.size() - 1) >= TO;
        lastIdx   = isTimeout ? TO : stim.size() - 1;
        count     = 0;
        for (int i = 0; i <= lastIdx; i++) count += int'(stim[i]);
        expTrojan = isTimeout || (gmin > gmax) || (count < int'(gmin)) || (count > int'(gmax));
    endfunction

    // Starts at the negedge where result_valid was first seen high.
    task automatic ackPhase(input int ackDelay, input bit ackEarly, input logic [CW-1:0] expCount,
                            input bit expTrojan);
        if (ackEarly) begin
            @(negedge clk);
            checkEq("ackHeldDrop", result_valid, 0);
        end else begin
            for (int k = 0; k < ackDelay; k++) begin
                @(negedge clk);
                checkEq("validHold", result_valid, 1);
                checkEq("countHold", delay_count, expCount);
            end
            result_ack = 1'b1;
            @(negedge clk);
            result_ack = 1'b0;
            checkEq("ackDrop", result_valid, 0);
        end
        checkEq("doneCount", delay_count, expCount);
        checkEq("doneTrojan", trojan, expTrojan);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            result_ack = 1'($urandom_range(0, 1));
            checkEq("doneValid", result_valid, 0);
            checkEq("doneBusy", busy, 0);
        end
        result_ack = 1'b0;
    endtask

    task automatic runMeasure(input logic [CW-1:0] gmin, input logic [CW-1:0] gmax,
                              input int ackDelay, input bit ackEarly, input bit withReset);
        bit       isTimeout;
        int       count;
        bit       expTrojan;
        int       lat;
        logic [CW-1:0] expCount;
        if (withReset) doReset();
        golden_min = gmin;
        golden_max = gmax;
        idleCycles();
        refModel(gmin, gmax, isTimeout, count, expTrojan);
        expQ.push_back(CW'(count));
        for (int i = 0; i < stim.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkEq("measBusy", busy, 1);
                checkEq("measValid", result_valid, 0);
            end
            ld_reg = stim[i]; fin = 1'b0;
            result_ack = ackEarly ? 1'b0 : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        if (isTimeout) begin
            ld_reg = 1'b1; result_ack = 1'b0;
            checkEq("toValid", result_valid, 1);
            checkEq("toErr", timeout_err, 1);
        end else begin
            ld_reg = 1'($urandom_range(0, 1)); fin = 1'b1; result_ack = ackEarly;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (lat == 1) checkEq("decideBusy", busy, 1);
            end while (!result_valid && lat < 10);
            checkEq("latency", lat, 2);
            checkEq("timeoutErr", timeout_err, 0);
        end
        expCount = expQ.pop_front();
        checkEq("delayCount", delay_count, expCount);
        checkEq("trojan", trojan, expTrojan);
        checkEq("protoErr", proto_err, 0);
        checkEq("holdBusy", busy, 0);
        ackPhase(ackDelay, ackEarly, expCount, expTrojan);
        fin = 1'b0;
    endtask

    task automatic runProto(input int ackDelay);
        doReset();
        idleCycles();
        @(negedge clk);
        fin = 1'b1; ld_reg = 1'($urandom_range(0, 1)); result_ack = 1'b0;
        @(negedge clk);
        checkEq("protoValid", result_valid, 1);
        checkEq("protoErr", proto_err, 1);
        checkEq("protoTrojan", trojan, 1);
        checkEq("protoCount", delay_count, 0);
        checkEq("protoTimeout", timeout_err, 0);
        ackPhase(ackDelay, 1'b0, '0, 1'b1);
        fin = 1'b0;
    endtask

    task automatic setOnes(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(1'b1);
    endtask

    initial begin
        int len;
        int kind;
        rst = 1'b1; ld_reg = 1'b0; fin = 1'b0; result_ack = 1'b0;
        golden_min = '0; golden_max = '0;

        setOnes(6);   runMeasure(5, 8, 2, 1'b0, 1'b1);   // nominal pass
        setOnes(12);  runMeasure(5, 8, 0, 1'b0, 1'b1);   // slow path
        setOnes(TO + 1); runMeasure(5, 8, 7, 1'b0, 1'b1); // timeout, late ack
        runProto(1);
        setOnes(5);   runMeasure(9, 3, 1, 1'b0, 1'b1);   // inverted window
        stim.delete();
        stim.push_back(1); stim.push_back(1); stim.push_back(0);
        stim.push_back(0); stim.push_back(1);
        runMeasure(3, 3, 0, 1'b1, 1'b1);                 // gaps, ack held high

        // Reset in the fourth MEASURE cycle, then a clean 5-cycle measurement.
        doReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_reg = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midReset");
        rst = 1'b0; ld_reg = 1'b0;
        setOnes(5); runMeasure(5, 5, 1, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                runProto($urandom_range(0, 4));
            end else begin
                len = (kind == 1) ? TO + 1 : $urandom_range(1, 14);
                stim.delete();
                stim.push_back(1'b1);
                for (int i = 1; i < len; i++) stim.push_back($urandom_range(0, 3) != 0);
                runMeasure(CW'($urandom_range(0, 12)), CW'($urandom_range(0, 14)),
                           $urandom_range(0, 5), (kind == 2), 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", nCompared);
        $fatal(1, "watchdog expired");
    end

endmodule
